// File: rtl/bcd_countdown_60_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and helpers for the two-digit BCD countdown
//               timer (digit type, FSM state type, load validity check).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } cd_state_t;

    localparam bcd_digit_t c_TENS_MAX_DEF  = 4'd5;
    localparam bcd_digit_t c_UNITS_MAX_DEF = 4'd9;

    // True when both digits of a {tens, units} preset are within their limits.
    function automatic logic is_valid_bcd60(
        input logic [7:0] v,
        input bcd_digit_t tens_max  = c_TENS_MAX_DEF,
        input bcd_digit_t units_max = c_UNITS_MAX_DEF
    );
        return (v[7:4] <= tens_max) && (v[3:0] <= units_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_countdown_60_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_60_if
// Description : Control/status bundle of the BCD countdown timer. The
//               master side drives the controls, the slave is the counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_countdown_60_if;

    logic       tick;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic [7:0] Q;
    logic       running;
    logic       zero;
    logic       done;
    logic       load_err;

    modport master (
        output tick, load, load_val, start, stop,
        input  Q, running, zero, done, load_err
    );

    modport slave (
        input  tick, load, load_val, start, stop,
        output Q, running, zero, done, load_err
    );

endinterface
`default_nettype wire

// File: rtl/bcd_countdown_60_digit_down.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_down
// Description : One loadable BCD down-counting digit. Wraps 0 -> max on a
//               decrement and reports a same-cycle borrow to the next digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_down
    import bcd_pkg::*;
(
    input  wire        clk,
    input  wire        rst,
    input  wire        en,
    input  wire        load,
    input  bcd_digit_t d,
    input  bcd_digit_t max,
    output bcd_digit_t q,
    output logic       borrow_out
);

    bcd_digit_t r_q;

    // Digit register: reset, then load, then decrement with wrap to max.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= d;
        end else if (en) begin
            r_q <= (r_q == 4'd0) ? max : (r_q - 4'd1);
        end
    end

    assign q          = r_q;
    assign borrow_out = en && (r_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_60.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_60
// Description : Loadable two-digit BCD down-counter (59..00) with
//               start/stop control, a done pulse on reaching 00 and a
//               rejected-load pulse. Both digits share clk; the tens digit
//               is enabled by the units borrow in the same cycle.
//               Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN
//               (reload the last accepted preset on the tick after 00).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_60
    import bcd_pkg::*;
#(
    parameter bcd_digit_t TENS_MAX  = 4'd5,
    parameter bcd_digit_t UNITS_MAX = 4'd9
)(
    input  wire               clk,
    input  wire               rst,
    bcd_countdown_60_if.slave bus
);

    cd_state_t  r_state;
    cd_state_t  w_state_nxt;
    logic       r_done;
    logic       r_load_err;
    logic       w_done_nxt;
    logic       w_load_ok;
    logic       w_load_bad;
    logic       w_dig_load;
    logic       w_dec;
    bcd_digit_t w_d_tens;
    bcd_digit_t w_d_units;
    bcd_digit_t w_q_tens;
    bcd_digit_t w_q_units;
    logic       w_units_borrow;
    logic       w_tens_borrow;
    logic       w_unused;
    logic [7:0] w_q;
    logic       w_zero;

    assign w_load_ok  = bus.load &&  is_valid_bcd60(bus.load_val, TENS_MAX, UNITS_MAX);
    assign w_load_bad = bus.load && !is_valid_bcd60(bus.load_val, TENS_MAX, UNITS_MAX);
    assign w_q        = {w_q_tens, w_q_units};
    assign w_zero     = (w_q == 8'h00);

    // The tens digit can never borrow while counting is gated at 00.
    assign w_unused   = w_tens_borrow;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [7:0] r_reload;

    // Reload register remembers the last accepted preset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= 8'h00;
        end else if (w_load_ok) begin
            r_reload <= bus.load_val;
        end
    end
`endif

    // State, done and load-error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_bad;
        end
    end

    // Next state and datapath controls, priority load > stop > start > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_dig_load  = 1'b0;
        w_d_tens    = bus.load_val[7:4];
        w_d_units   = bus.load_val[3:0];
        w_dec       = 1'b0;
        w_done_nxt  = 1'b0;
        if (w_load_ok) begin
            w_dig_load  = 1'b1;
            w_state_nxt = IDLE;
        end else if (bus.stop) begin
            if (r_state == RUN) begin
                w_state_nxt = IDLE;
            end
        end else if (bus.start) begin
            if ((r_state == IDLE) && !w_zero) begin
                w_state_nxt = RUN;
            end
        end else if (bus.tick && (r_state == RUN)) begin
            if (w_zero) begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                if (r_reload == 8'h00) begin
                    w_state_nxt = EXPIRED;
                end else begin
                    w_dig_load = 1'b1;
                    w_d_tens   = r_reload[7:4];
                    w_d_units  = r_reload[3:0];
                end
`else
                w_state_nxt = EXPIRED;
`endif
            end else begin
                w_dec = 1'b1;
                if (w_q == 8'h01) begin
                    w_done_nxt = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                    if (r_reload == 8'h00) begin
                        w_state_nxt = EXPIRED;
                    end
`else
                    w_state_nxt = EXPIRED;
`endif
                end
            end
        end
    end

    bcd_digit_down u_units (
        .clk        (clk),
        .rst        (rst),
        .en         (w_dec),
        .load       (w_dig_load),
        .d          (w_d_units),
        .max        (UNITS_MAX),
        .q          (w_q_units),
        .borrow_out (w_units_borrow)
    );

    bcd_digit_down u_tens (
        .clk        (clk),
        .rst        (rst),
        .en         (w_units_borrow),
        .load       (w_dig_load),
        .d          (w_d_tens),
        .max        (TENS_MAX),
        .q          (w_q_tens),
        .borrow_out (w_tens_borrow)
    );

    assign bus.Q        = w_q;
    assign bus.running  = (r_state == RUN);
    assign bus.zero     = w_zero;
    assign bus.done     = r_done;
    assign bus.load_err = r_load_err;

endmodule
`default_nettype wire
